// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle signed radix-2 Booth multiplier.
// One Booth step per clock; start/busy/done handshake; 2*WIDTH signed result.
// Optional overflow flag output enabled by defining SEQ_MULTIPLIER_OVF_EN.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
`ifdef SEQ_MULTIPLIER_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   q;
  logic [WIDTH:0]     a;
  logic               q_1;
  logic [CW-1:0]      count;

  logic [WIDTH:0]     m_ext;
  logic [WIDTH:0]     a_sum;
  logic [WIDTH:0]     a_sh;
  logic [WIDTH-1:0]   q_sh;
  logic [2*WIDTH-1:0] product;

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign m_ext = {m[WIDTH-1], m};

  // One Booth step: conditional add/subtract of the sign-extended multiplicand, then arithmetic shift
  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b01:   a_sum = a + m_ext;
      2'b10:   a_sum = a - m_ext;
      default: a_sum = a;
    endcase
    a_sh    = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_sh    = {a_sum[0], q[WIDTH-1:1]};
    product = {a_sh[WIDTH-1:0], q_sh};
  end

  // Control FSM and datapath registers: capture on start, step in RUN, publish the product on DONE entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      m      <= '0;
      q      <= '0;
      a      <= '0;
      q_1    <= 1'b0;
      count  <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m     <= num1;
            q     <= num2;
            a     <= '0;
            q_1   <= 1'b0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          a     <= a_sh;
          q     <= q_sh;
          q_1   <= q[0];
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            result <= product;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_MULTIPLIER_OVF_EN
  // Overflow flag is registered alongside result: set when the product's upper bits are not a pure sign extension
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == RUN && count == CW'(WIDTH - 1)) begin
      ovf <= (product[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){product[2*WIDTH-1]}});
    end
  end
`endif

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: scoreboard bench for seq_multiplier (WIDTH = 8).
// Stimulus pushes expected products into a queue; a monitor pops on every done pulse.
module tb_seq_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  num1;
  logic [7:0]  num2;
  logic        busy;
  logic        done;
  logic [15:0] result;
`ifdef SEQ_MULTIPLIER_OVF_EN
  logic        ovf;
`endif

  int compared;
  int mismatched;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    string       name;
  } exp_t;

  exp_t sbq[$];

  seq_multiplier #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .num1   (num1),
    .num2   (num2),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef SEQ_MULTIPLIER_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request; when push is set the expected product goes into the scoreboard
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expRes,
                               input logic expOvf, input bit push, input string name);
    exp_t e;
    @(negedge clk);
    num1  = a;
    num2  = b;
    start = 1'b1;
    if (push) begin
      e.res  = expRes;
      e.ovf  = expOvf;
      e.name = name;
      sbq.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    num1  = 8'h00;
    num2  = 8'h00;
    checkOutput({name, "_busy_rise"}, {15'd0, busy}, 16'd1);
  endtask

  // Count negedges until done, checking latency and that result never moves while waiting
  task automatic waitDone(input string name, input int expCycles);
    int cycles;
    logic [15:0] r0;
    bit stable;
    cycles = 0;
    stable = 1'b1;
    r0 = result;
    do begin
      @(negedge clk);
      cycles++;
      if (!done && result !== r0) stable = 1'b0;
    end while (!done && cycles < 30);
    checkOutput({name, "_latency"}, 16'(cycles), 16'(expCycles));
    checkOutput({name, "_stable"}, {15'd0, stable}, 16'd1);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_done: got result 0x%0h expected no done pulse", result);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput({e.name, "_result"}, result, e.res);
`ifdef SEQ_MULTIPLIER_OVF_EN
        checkOutput({e.name, "_ovf"}, {15'd0, ovf}, {15'd0, e.ovf});
`endif
      end
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n = 1'b0;
    start = 1'b0;
    num1  = 8'h00;
    num2  = 8'h00;

    #1;
    checkOutput("reset_busy",   {15'd0, busy}, 16'd0);
    checkOutput("reset_done",   {15'd0, done}, 16'd0);
    checkOutput("reset_result", result,        16'h0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic product and its handshake timing
    applyStimulus(8'd3, 8'd5, 16'h000F, 1'b0, 1'b1, "basic_3x5");
    waitDone("basic_3x5", 8);
    @(negedge clk);
    checkOutput("basic_busy_fall", {15'd0, busy}, 16'd0);
    checkOutput("basic_done_fall", {15'd0, done}, 16'd0);
    checkOutput("basic_hold",      result,        16'h000F);

    // Mixed signs
    applyStimulus(8'hF9, 8'd6, 16'hFFD6, 1'b0, 1'b1, "neg7x6");
    waitDone("neg7x6", 8);
    applyStimulus(8'd127, 8'hFF, 16'hFF81, 1'b0, 1'b1, "127xneg1");
    waitDone("127xneg1", 8);

    // Most-negative operand corners
    applyStimulus(8'h80, 8'h80, 16'h4000, 1'b1, 1'b1, "neg128xneg128");
    waitDone("neg128xneg128", 8);
    applyStimulus(8'h80, 8'd1, 16'hFF80, 1'b0, 1'b1, "neg128x1");
    waitDone("neg128x1", 8);

    // Zero operand
    applyStimulus(8'h00, 8'hA5, 16'h0000, 1'b0, 1'b1, "zero_x");
    waitDone("zero_x", 8);

    // A start pulse while busy must be ignored
    applyStimulus(8'd4, 8'd4, 16'h0010, 1'b0, 1'b1, "busy_4x4");
    repeat (2) @(negedge clk);
    num1  = 8'd9;
    num2  = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("busy_4x4", 5);
    @(negedge clk);
    checkOutput("busy_ignore_busy_fall", {15'd0, busy}, 16'd0);
    repeat (12) @(negedge clk);
    checkOutput("busy_ignore_idle",   {15'd0, busy}, 16'd0);
    checkOutput("busy_ignore_result", result,        16'h0010);

    // Asynchronous reset in the middle of a run
    applyStimulus(8'd100, 8'd100, 16'h2710, 1'b0, 1'b0, "reset_mid");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy",   {15'd0, busy}, 16'd0);
    checkOutput("midreset_done",   {15'd0, done}, 16'd0);
    checkOutput("midreset_result", result,        16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'd2, 8'hFD, 16'hFFFA, 1'b0, 1'b1, "after_reset_2xneg3");
    waitDone("after_reset_2xneg3", 8);

    // Back-to-back: start held high gives a product every WIDTH+2 cycles
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      e.res  = 16'h0064;
      e.ovf  = 1'b0;
      e.name = $sformatf("b2b_%0d", i);
      sbq.push_back(e);
    end
    num1  = 8'd10;
    num2  = 8'd10;
    start = 1'b1;
    waitDone("b2b_0", 9);
    waitDone("b2b_1", 10);
    waitDone("b2b_2", 10);
    start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("b2b_idle_busy", {15'd0, busy}, 16'd0);
    checkOutput("b2b_hold",      result,        16'h0064);

    checkOutput("scoreboard_drained", 16'(sbq.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
